pc_redirect_ctrl: RTL and testbench

//  Control side of the fetch-stage redirect interface. Collects taken-branch and

---
 rtl/pc_redirect_ctrl.sv | 146 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch redirect select/flush controller; optional stats via REDIRECT_STATS_EN
module pc_redirect_ctrl #(
    parameter int EX_FLUSH = 2,
    parameter int WB_FLUSH = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        jr_req,
    input  logic [31:0] jr_value,
    input  logic        j_req,
    input  logic [31:0] j_target,
    input  logic        load_use,
    input  logic        mem_hold,
    output logic        branchSel,
    output logic        Jump,
    output logic        JumpReg,
    output logic        PCWrite,
    output logic [31:0] branchTrue,
    output logic [31:0] readData1_ex,
    output logic [31:0] jumpAddr_wb,
    output logic        flush_ifid,
    output logic        flush_idex
`ifdef REDIRECT_STATS_EN
    ,
    output logic [15:0] redirCount,
    output logic [15:0] stallCount
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] EX_LOAD = CNT_W'(EX_FLUSH - 1);
    localparam logic [CNT_W-1:0] WB_LOAD = CNT_W'(WB_FLUSH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             any_req;

    // Jump is the only WB-resolved select; it picks the longer flush window.
    assign cnt_load = Jump ? WB_LOAD : EX_LOAD;
    assign any_req  = j_req | jr_req | br_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (any_req) state_next = REDIR;
            REDIR:   if (PCWrite) state_next = (cnt_load == '0) ? RUN : FLUSH;
            FLUSH:   if (!mem_hold && cnt == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A pending redirect must reach the PC, so load_use only stalls in RUN.
    always_comb begin
        PCWrite = reset && !mem_hold && !(load_use && state == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branchSel    <= 1'b0;
            Jump         <= 1'b0;
            JumpReg      <= 1'b0;
            branchTrue   <= '0;
            readData1_ex <= '0;
            jumpAddr_wb  <= '0;
            flush_ifid   <= 1'b0;
            flush_idex   <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                RUN: begin
                    flush_ifid <= 1'b0;
                    flush_idex <= 1'b0;
                    if (j_req) begin
                        Jump        <= 1'b1;
                        jumpAddr_wb <= j_target;
                    end else if (jr_req) begin
                        JumpReg      <= 1'b1;
                        readData1_ex <= jr_value;
                    end else if (br_req) begin
                        branchSel  <= 1'b1;
                        branchTrue <= br_target;
                    end
                end
                REDIR: begin
                    if (PCWrite) begin
                        branchSel  <= 1'b0;
                        Jump       <= 1'b0;
                        JumpReg    <= 1'b0;
                        flush_ifid <= 1'b1;
                        flush_idex <= 1'b1;
                        cnt        <= cnt_load;
                    end
                end
                FLUSH: begin
                    if (!mem_hold) begin
                        if (cnt == '0) begin
                            flush_ifid <= 1'b0;
                            flush_idex <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    flush_ifid <= 1'b0;
                    flush_idex <= 1'b0;
                end
            endcase
        end
    end

`ifdef REDIRECT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirCount <= '0;
            stallCount <= '0;
        end else begin
            if (state == REDIR && PCWrite && redirCount != 16'hFFFF) begin
                redirCount <= redirCount + 16'd1;
            end
            if (!PCWrite && stallCount != 16'hFFFF) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed plus random checks of pc_redirect_ctrl against a cycle model
module tb_pc_redirect_ctrl;

    localparam int EX_FLUSH = 2;
    localparam int WB_FLUSH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_req, jr_req, j_req, load_use, mem_hold;
    logic [31:0] br_target, jr_value, j_target;
    logic        branchSel, Jump, JumpReg, PCWrite, flush_ifid, flush_idex;
    logic [31:0] branchTrue, readData1_ex, jumpAddr_wb;
`ifdef REDIRECT_STATS_EN
    logic [15:0] redirCount, stallCount;
`endif

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.EX_FLUSH(EX_FLUSH), .WB_FLUSH(WB_FLUSH), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .br_req(br_req), .br_target(br_target),
        .jr_req(jr_req), .jr_value(jr_value),
        .j_req(j_req), .j_target(j_target),
        .load_use(load_use), .mem_hold(mem_hold),
        .branchSel(branchSel), .Jump(Jump), .JumpReg(JumpReg), .PCWrite(PCWrite),
        .branchTrue(branchTrue), .readData1_ex(readData1_ex), .jumpAddr_wb(jumpAddr_wb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex)
`ifdef REDIRECT_STATS_EN
        , .redirCount(redirCount), .stallCount(stallCount)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Model: pending redirect kind (0 none, 1 br, 2 jr, 3 j) and flush cycles still owed.
    int          pend;
    int          flush_left;
    logic [31:0] m_br, m_jr, m_j;
    int          m_redir, m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        pend = 0; flush_left = 0;
        m_br = '0; m_jr = '0; m_j = '0;
        m_redir = 0; m_stall = 0;
    endtask

    function automatic logic exp_pcwrite();
        return reset && !mem_hold && !(load_use && pend == 0 && flush_left == 0);
    endfunction

    task automatic compare_all();
        check("branchSel", {31'b0, branchSel}, {31'b0, pend == 1});
        check("JumpReg", {31'b0, JumpReg}, {31'b0, pend == 2});
        check("Jump", {31'b0, Jump}, {31'b0, pend == 3});
        check("PCWrite", {31'b0, PCWrite}, {31'b0, exp_pcwrite()});
        check("flush_ifid", {31'b0, flush_ifid}, {31'b0, flush_left > 0});
        check("flush_idex", {31'b0, flush_idex}, {31'b0, flush_left > 0});
        check("branchTrue", branchTrue, m_br);
        check("readData1_ex", readData1_ex, m_jr);
        check("jumpAddr_wb", jumpAddr_wb, m_j);
`ifdef REDIRECT_STATS_EN
        check("redirCount", {16'b0, redirCount}, m_redir);
        check("stallCount", {16'b0, stallCount}, m_stall);
`endif
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            if (!exp_pcwrite() && m_stall < 65535) m_stall++;
            if (pend != 0) begin
                if (!mem_hold) begin
                    flush_left = (pend == 3) ? WB_FLUSH : EX_FLUSH;
                    pend = 0;
                    if (m_redir < 65535) m_redir++;
                end
            end else if (flush_left > 0) begin
                if (!mem_hold) flush_left--;
            end else if (j_req) begin
                pend = 3; m_j = j_target;
            end else if (jr_req) begin
                pend = 2; m_jr = jr_value;
            end else if (br_req) begin
                pend = 1; m_br = br_target;
            end
        end
    endtask

    // Inputs are already driven; check mid-cycle, then advance one edge.
    task automatic step();
        if (!reset) model_reset();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        br_req = 0; jr_req = 0; j_req = 0; load_use = 0; mem_hold = 0; reset = 1;
        br_target = $urandom; jr_value = $urandom; j_target = $urandom;
    endtask

    initial begin
        quiet();
        reset = 0;
        model_reset();
        #2;
        check("rst_pcwrite", {31'b0, PCWrite}, 32'd0);
        check("rst_flush", {31'b0, flush_ifid}, 32'd0);
        step();
        reset = 1;
        step();

        // branch taken in RUN
        br_req = 1; br_target = 32'h40;
        step();
        quiet();
        check("t1_sel", {31'b0, branchSel}, 32'd1);
        check("t1_target", branchTrue, 32'h40);
        repeat (4) step();

        // simultaneous requests: j wins
        j_req = 1; jr_req = 1; br_req = 1; j_target = 32'h100;
        step();
        quiet();
        check("t2_jump", {31'b0, Jump}, 32'd1);
        check("t2_others", {30'b0, JumpReg, branchSel}, 32'd0);
        check("t2_target", jumpAddr_wb, 32'h100);
        repeat (6) step();

        // jr under memory hold
        jr_req = 1; jr_value = 32'h10; mem_hold = 1;
        step();
        jr_req = 0;
        repeat (2) step();
        check("t3_sel", {31'b0, JumpReg}, 32'd1);
        check("t3_value", readData1_ex, 32'h10);
        mem_hold = 0;
        repeat (4) step();

        // load-use stall in RUN
        load_use = 1;
        step();
        load_use = 0;
        repeat (2) step();

        // request during FLUSH is ignored, then reset mid-FLUSH
        br_req = 1; br_target = 32'h80;
        step();
        br_req = 0;
        step();
        br_req = 1; br_target = 32'hDEAD;
        step();
        br_req = 0;
        check("t5_ignored", {31'b0, branchSel}, 32'd0);
        check("t5_in_flush", {31'b0, flush_ifid}, 32'd1);
        reset = 0;
        #1;
        check("t5_async_flush", {30'b0, flush_ifid, flush_idex}, 32'd0);
        check("t5_async_pcw", {31'b0, PCWrite}, 32'd0);
        check("t5_async_tgt", branchTrue, 32'd0);
        step();
        reset = 1;
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            br_req    = ($urandom_range(0, 3) == 0);
            jr_req    = ($urandom_range(0, 5) == 0);
            j_req     = ($urandom_range(0, 7) == 0);
            load_use  = ($urandom_range(0, 4) == 0);
            mem_hold  = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 99) != 0);
            br_target = $urandom; jr_value = $urandom; j_target = $urandom;
            step();
        end
        quiet();
        step();

`ifdef REDIRECT_STATS_EN
        reset = 0;
        step();
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            br_req = 1; step(); br_req = 0;
            repeat (3) step();
        end
        mem_hold = 1;
        repeat (5) step();
        mem_hold = 0;
        step();
        check("stat_redir3", {16'b0, redirCount}, 32'd3);
        check("stat_stall5", {16'b0, stallCount}, 32'd5);
        mem_hold = 1;
        repeat (65600) @(posedge clk);
        #1;
        check("stat_stall_sat", {16'b0, stallCount}, 32'hFFFF);
        mem_hold = 0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
